// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions for counter sizing.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_sub_full_adder_bit.sv
// One-bit full adder; the combinational slice of the serial datapath.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: operands accepted in IDLE, one bit per cycle in RUN,
// result held in DONE until the consumer takes it.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         c,
  input  logic         rn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         co,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic          carry;
  logic          sub_r;
  logic [CW-1:0] cnt;
  logic          fa_s;
  logic          fa_co;
  logic [W-1:0]  y_shift;

  full_adder_bit u_fa (
    .a  (ra[0]),
    .b  (rb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so the word is LSB-aligned after W shifts.
  generate
    if (W > 1) begin : g_shift
      assign y_shift = {fa_s, y[W-1:1]};
    end else begin : g_shift1
      assign y_shift = fa_s;
    end
  endgenerate

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
      cnt   <= '0;
      y     <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1, so the inverted operand and carry-in are set here.
            ra    <= a;
            rb    <= sub ? ~b : b;
            carry <= sub;
            sub_r <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= fa_co;
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          y     <= y_shift;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            // Final carry of a + ~b + 1 is the inverse of the borrow.
            co    <= sub_r ? ~fa_co : fa_co;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
